// File: rtl/jpeg_ycbcr_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : jpeg_ycbcr_ctrl_if
//  Description : Handshake bundle between the IDCT writer, the YCbCr MCU
//                buffer sequencer and the YCbCr2RGB reader.
//                slave  : sequencer side (jpeg_ycbcr_ctrl)
//                master : surrounding pipeline / testbench side
//  Signals     : BlockDone, BlockColor[2:0]  block-written notification
//                InReady                     buffer accepting writes
//                DataOutAddress[7:0]         buffer read address
//                OutReady                    downstream sample request
//                OutEnable, OutLast          read data valid / final sample
//                McuDone, Error              MCU released / sticky error
//                McuCount[15:0]              only with JPEG_YCBCR_CTRL_MCU_CNT_EN
//  Config      : JPEG_YCBCR_CTRL_MCU_CNT_EN adds McuCount
//  Revision    : 1.0 - initial release
// ============================================================================
interface jpeg_ycbcr_ctrl_if;
   logic       BlockDone;
   logic [2:0] BlockColor;
   logic       InReady;
   logic [7:0] DataOutAddress;
   logic       OutReady;
   logic       OutEnable;
   logic       OutLast;
   logic       McuDone;
   logic       Error;
`ifdef JPEG_YCBCR_CTRL_MCU_CNT_EN
   logic [15:0] McuCount;

   modport slave (
      input  BlockDone, BlockColor, OutReady,
      output InReady, DataOutAddress, OutEnable, OutLast, McuDone, Error, McuCount
   );
   modport master (
      output BlockDone, BlockColor, OutReady,
      input  InReady, DataOutAddress, OutEnable, OutLast, McuDone, Error, McuCount
   );
`else
   modport slave (
      input  BlockDone, BlockColor, OutReady,
      output InReady, DataOutAddress, OutEnable, OutLast, McuDone, Error
   );
   modport master (
      output BlockDone, BlockColor, OutReady,
      input  InReady, DataOutAddress, OutEnable, OutLast, McuDone, Error
   );
`endif
endinterface
`default_nettype wire

// File: rtl/jpeg_ycbcr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : jpeg_ycbcr_ctrl
//  Description : Sequencer for a 4:2:0 YCbCr MCU buffer (Y0..Y3, Cb, Cr).
//                Collects block-written notifications, then issues read
//                addresses 0..255 throttled by OutReady, flags valid samples
//                one cycle later and releases the buffer for the next MCU.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous reset, active low
//                bus  - jpeg_ycbcr_ctrl_if.slave (see interface header)
//  Config      : JPEG_YCBCR_CTRL_MCU_CNT_EN - adds 16-bit wrapping MCU counter
//  Revision    : 1.0 - initial release
// ============================================================================
module jpeg_ycbcr_ctrl (
   input  wire logic          clk,
   input  wire logic          rst,
   jpeg_ycbcr_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic [5:0] C_MASK_FULL = 6'h3F;
   localparam logic [7:0] C_ADDR_LAST = 8'hFF;

   state_t     r_state;
   logic [5:0] r_mask;
   logic [7:0] r_addr;
   logic       r_in_ready;
   logic       r_out_en;
   logic       r_out_last;
   logic       r_mcu_done;
   logic       r_error;

   logic       w_col_valid;
   logic [5:0] w_col_bit;
   logic [5:0] w_mask_nxt;
   logic       w_issue;
   logic       w_issue_last;

   always_comb begin
      w_col_valid  = (bus.BlockColor <= 3'd5);
      w_col_bit    = w_col_valid ? (6'b000001 << bus.BlockColor) : 6'b000000;
      w_mask_nxt   = r_mask | w_col_bit;
      w_issue      = (r_state == ST_READ) && bus.OutReady;
      w_issue_last = w_issue && (r_addr == C_ADDR_LAST);
   end

`ifdef JPEG_YCBCR_CTRL_MCU_CNT_EN
   logic [15:0] r_mcu_cnt;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= ST_FILL;
         r_mask     <= 6'b0;
         r_addr     <= 8'd0;
         r_in_ready <= 1'b1;
         r_out_en   <= 1'b0;
         r_out_last <= 1'b0;
         r_mcu_done <= 1'b0;
         r_error    <= 1'b0;
`ifdef JPEG_YCBCR_CTRL_MCU_CNT_EN
         r_mcu_cnt  <= 16'd0;
`endif
      end else begin
         // Read data valid/last/done follow the issuing edge by one cycle;
         // the cycle carrying the last sample is the DRAIN cycle.
         r_out_en   <= w_issue;
         r_out_last <= w_issue_last;
         r_mcu_done <= w_issue_last;

         if (bus.BlockDone && (!w_col_valid || (r_state != ST_FILL)))
            r_error <= 1'b1;

         case (r_state)
            ST_FILL: begin
               if (bus.BlockDone && w_col_valid) begin
                  r_mask <= w_mask_nxt;
                  if (w_mask_nxt == C_MASK_FULL) begin
                     r_state    <= ST_READ;
                     r_in_ready <= 1'b0;
                     r_addr     <= 8'd0;
                  end
               end
            end
            ST_READ: begin
               if (bus.OutReady) begin
                  // 8-bit increment wraps 255 -> 0 as the MCU finishes
                  r_addr <= r_addr + 8'd1;
                  if (r_addr == C_ADDR_LAST)
                     r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               r_state    <= ST_FILL;
               r_mask     <= 6'b0;
               r_in_ready <= 1'b1;
`ifdef JPEG_YCBCR_CTRL_MCU_CNT_EN
               r_mcu_cnt  <= r_mcu_cnt + 16'd1;
`endif
            end
            default: begin
               r_state <= ST_FILL;
            end
         endcase
      end
   end

   assign bus.InReady        = r_in_ready;
   assign bus.DataOutAddress = r_addr;
   assign bus.OutEnable      = r_out_en;
   assign bus.OutLast        = r_out_last;
   assign bus.McuDone        = r_mcu_done;
   assign bus.Error          = r_error;
`ifdef JPEG_YCBCR_CTRL_MCU_CNT_EN
   assign bus.McuCount       = r_mcu_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jpeg_ycbcr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jpeg_ycbcr_ctrl
//  Description : Self-checking bench for jpeg_ycbcr_ctrl. Fill-phase
//                behaviour comes from a vector table; READ phases, error
//                injection and reset abort are hand-written sequences.
//  Config      : JPEG_YCBCR_CTRL_MCU_CNT_EN enables the McuCount checks
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jpeg_ycbcr_ctrl;

   logic clk;
   logic rst;
   jpeg_ycbcr_ctrl_if bus ();

   jpeg_ycbcr_ctrl u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       bd;
      logic [2:0] col;
      logic       e_inrdy;
      logic       e_err;
   } vec_t;

   vec_t vecs [27];
   int   errors = 0;
   int   checks = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic setv(input int i, input logic bd, input logic [2:0] col,
                       input logic inrdy, input logic err);
      vecs[i].bd      = bd;
      vecs[i].col     = col;
      vecs[i].e_inrdy = inrdy;
      vecs[i].e_err   = err;
   endtask

   task automatic do_reset();
      rst            = 1'b0;
      bus.BlockDone  = 1'b0;
      bus.BlockColor = 3'd0;
      bus.OutReady   = 1'b0;
      step();
      check("rst_inready", bus.InReady, 1);
      check("rst_addr",    bus.DataOutAddress, 0);
      check("rst_oen",     bus.OutEnable, 0);
      check("rst_last",    bus.OutLast, 0);
      check("rst_mcudone", bus.McuDone, 0);
      check("rst_error",   bus.Error, 0);
      rst = 1'b1;
   endtask

   // Fill-phase vectors: OutReady held low, no read activity expected.
   task automatic apply_vecs(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         bus.BlockDone  = vecs[i].bd;
         bus.BlockColor = vecs[i].col;
         bus.OutReady   = 1'b0;
         step();
         check("vec_inready", bus.InReady, vecs[i].e_inrdy);
         check("vec_error",   bus.Error,   vecs[i].e_err);
         check("vec_oen",     bus.OutEnable, 0);
         check("vec_mcudone", bus.McuDone, 0);
         check("vec_addr",    bus.DataOutAddress, 0);
      end
      bus.BlockDone = 1'b0;
   endtask

   // Runs one READ phase. mode 0: OutReady held 1; mode 1: OutReady 1,0,1,0...
   // inject_at: cycle with a BlockDone colour 2 (-1 = none).
   // abort_at : reset when the address reaches this value (-1 = none).
   task automatic run_read(input int mode, input int inject_at, input int abort_at,
                           input logic exp_err);
      int   issued = 0;
      int   cyc    = 0;
      logic iss;
      bit   done   = 0;
      while (!done && cyc < 2000) begin
         bus.OutReady   = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
         bus.BlockDone  = (cyc == inject_at);
         bus.BlockColor = 3'd2;
         if (abort_at >= 0 && issued == abort_at) begin
            check("abort_addr", bus.DataOutAddress, abort_at);
            do_reset();
            return;
         end
         iss = bus.OutReady;
         step();
         check("rd_oen",     bus.OutEnable, iss);
         check("rd_last",    bus.OutLast, iss && issued == 255);
         check("rd_mcudone", bus.McuDone, iss && issued == 255);
         check("rd_inready", bus.InReady, 0);
         if (iss) issued++;
         check("rd_addr", bus.DataOutAddress, issued % 256);
         if (issued == 256) done = 1;
         cyc++;
      end
      if (!done) check("rd_timeout", 0, 1);
      bus.OutReady  = 1'b0;
      bus.BlockDone = 1'b0;
      step();
      check("post_inready", bus.InReady, 1);
      check("post_mcudone", bus.McuDone, 0);
      check("post_oen",     bus.OutEnable, 0);
      check("post_addr",    bus.DataOutAddress, 0);
      check("post_error",   bus.Error, exp_err);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // test 1 fill: 0..5 consecutive
      for (int i = 0; i < 6; i++) setv(i, 1'b1, 3'(i), (i < 5), 1'b0);
      // test 2 fill: 5,4,0,0,3,1,2
      setv(6,  1'b1, 3'd5, 1'b1, 1'b0);
      setv(7,  1'b1, 3'd4, 1'b1, 1'b0);
      setv(8,  1'b1, 3'd0, 1'b1, 1'b0);
      setv(9,  1'b1, 3'd0, 1'b1, 1'b0);
      setv(10, 1'b1, 3'd3, 1'b1, 1'b0);
      setv(11, 1'b1, 3'd1, 1'b1, 1'b0);
      setv(12, 1'b1, 3'd2, 1'b0, 1'b0);
      // test 4b fill: invalid colour first, then 0..5
      setv(13, 1'b1, 3'd7, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) setv(14 + i, 1'b1, 3'(i), (i < 5), 1'b1);
      // test 5 refill after reset: 0..4, idle, 5
      for (int i = 0; i < 5; i++) setv(20 + i, 1'b1, 3'(i), 1'b1, 1'b0);
      setv(25, 1'b0, 3'd5, 1'b1, 1'b0);
      setv(26, 1'b1, 3'd5, 1'b0, 1'b0);

      rst            = 1'b0;
      bus.BlockDone  = 1'b0;
      bus.BlockColor = 3'd0;
      bus.OutReady   = 1'b0;
      do_reset();

      // 1: straight MCU, OutReady held
      apply_vecs(0, 5);
      run_read(0, -1, -1, 1'b0);

      // 2: out-of-order with duplicate, then 3: toggling OutReady
      apply_vecs(6, 12);
      run_read(1, -1, -1, 1'b0);

      // 4a: BlockDone during READ sets Error, read unaffected
      apply_vecs(0, 5);
      run_read(0, 3, -1, 1'b1);

      // 4b: invalid colour in FILL sets Error, mask unaffected
      do_reset();
      apply_vecs(13, 19);
      run_read(0, -1, -1, 1'b1);

      // 5: reset at address 100, then a clean MCU from an empty mask
      do_reset();
      apply_vecs(0, 5);
      run_read(0, -1, 100, 1'b0);
      apply_vecs(20, 26);
      run_read(0, -1, -1, 1'b0);

`ifdef JPEG_YCBCR_CTRL_MCU_CNT_EN
      // 6: MCU counter
      do_reset();
      check("cnt_reset", bus.McuCount, 0);
      for (int m = 0; m < 3; m++) begin
         apply_vecs(0, 5);
         run_read(0, -1, -1, 1'b0);
      end
      check("cnt_three", bus.McuCount, 3);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
